// File: rtl/zx_vram_pkg.sv
// Shared types for the screen-page VRAM arbiter: requester tags carried
// alongside each RAM access so the returning data can be routed.
package zx_vram_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_LDR
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   we;
    } ret_tag_t;

    // A tag completes as a read when it belongs to `who` and is not a write.
    function automatic logic tag_is_read(input ret_tag_t t, input owner_e who);
        return (t.owner == who) && !t.we;
    endfunction

    function automatic logic tag_is_write(input ret_tag_t t, input owner_e who);
        return (t.owner == who) && t.we;
    endfunction

endpackage

// File: rtl/vram_arb_retpipe.sv
// Return path of the VRAM arbiter: tracks who owns each access in flight and
// steers RAM read data and completion pulses to exactly one requester.
module vram_arb_retpipe
    import zx_vram_pkg::*;
#(
    parameter int DW = VRAM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  ret_tag_t      i_tag,
    input  logic [DW-1:0] i_mem_dout,
    output logic [DW-1:0] o_vid_dout,
    output logic          o_vid_valid,
    output logic [DW-1:0] o_cpu_dout,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_ldr_dout,
    output logic          o_ldr_ack
);

    // r_s1 lines up with the access on mem_*, r_s2 with its data on i_mem_dout.
    ret_tag_t r_s1;
    ret_tag_t r_s2;

    logic w_rd_vid;
    logic w_rd_cpu;
    logic w_rd_ldr;
    logic w_wr_cpu;
    logic w_wr_ldr;

    assign w_rd_vid = (r_s2.owner == OWN_VID);
    assign w_rd_cpu = tag_is_read(r_s2, OWN_CPU);
    assign w_rd_ldr = tag_is_read(r_s2, OWN_LDR);
    // Writes complete one stage earlier: nothing comes back from the RAM.
    assign w_wr_cpu = tag_is_write(r_s1, OWN_CPU);
    assign w_wr_ldr = tag_is_write(r_s1, OWN_LDR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1        <= '{owner: OWN_NONE, we: 1'b0};
            r_s2        <= '{owner: OWN_NONE, we: 1'b0};
            o_vid_dout  <= '0;
            o_vid_valid <= 1'b0;
            o_cpu_dout  <= '0;
            o_cpu_ack   <= 1'b0;
            o_ldr_dout  <= '0;
            o_ldr_ack   <= 1'b0;
        end else begin
            r_s1        <= i_tag;
            r_s2        <= r_s1;
            o_vid_valid <= w_rd_vid;
            o_cpu_ack   <= w_rd_cpu | w_wr_cpu;
            o_ldr_ack   <= w_rd_ldr | w_wr_ldr;
            if (w_rd_vid) begin
                o_vid_dout <= i_mem_dout;
            end
            if (w_rd_cpu) begin
                o_cpu_dout <= i_mem_dout;
            end
            if (w_rd_ldr) begin
                o_ldr_dout <= i_mem_dout;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video > CPU > loader, with a starvation guard
// that lets a long-waiting loader overtake the CPU (never the video fetch).
module vram_arbiter
    import zx_vram_pkg::*;
#(
    parameter int AW           = VRAM_AW,
    parameter int DW           = VRAM_DW,
    parameter int LDR_MAX_WAIT = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_din,
    output logic [DW-1:0] ldr_dout,
    output logic          ldr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int            CW       = $clog2(LDR_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(LDR_MAX_WAIT);

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_din;
    logic          r_cpu_busy;
    logic          r_ldr_busy;
    logic [CW-1:0] r_ldr_wait;

    logic          w_cpu_elig;
    logic          w_ldr_elig;
    logic          w_ldr_starved;
    owner_e        w_grant;
    logic [AW-1:0] w_nxt_addr;
    logic          w_nxt_we;
    logic [DW-1:0] w_nxt_din;
    ret_tag_t      w_tag;

    // One outstanding transaction per requester: busy from grant until its ack.
    assign w_cpu_elig    = cpu_req & ~r_cpu_busy;
    assign w_ldr_elig    = ldr_req & ~r_ldr_busy;
    assign w_ldr_starved = (r_ldr_wait == WAIT_MAX);

    always_comb begin
        w_grant = OWN_NONE;
        if (vid_req) begin
            w_grant = OWN_VID;
        end else if (w_ldr_elig && w_ldr_starved) begin
            w_grant = OWN_LDR;
        end else if (w_cpu_elig) begin
            w_grant = OWN_CPU;
        end else if (w_ldr_elig) begin
            w_grant = OWN_LDR;
        end
    end

    always_comb begin
        w_nxt_addr = r_mem_addr;
        w_nxt_we   = 1'b0;
        w_nxt_din  = r_mem_din;
        case (w_grant)
            OWN_VID: begin
                w_nxt_addr = vid_addr;
            end
            OWN_CPU: begin
                w_nxt_addr = cpu_addr;
                w_nxt_we   = cpu_we;
                if (cpu_we) begin
                    w_nxt_din = cpu_din;
                end
            end
            OWN_LDR: begin
                w_nxt_addr = ldr_addr;
                w_nxt_we   = ldr_we;
                if (ldr_we) begin
                    w_nxt_din = ldr_din;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_tag = '{owner: w_grant, we: w_nxt_we};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
        end else begin
            r_mem_addr <= w_nxt_addr;
            r_mem_we   <= w_nxt_we;
            r_mem_din  <= w_nxt_din;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cpu_busy <= 1'b0;
            r_ldr_busy <= 1'b0;
        end else begin
            if (w_grant == OWN_CPU) begin
                r_cpu_busy <= 1'b1;
            end else if (cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end
            if (w_grant == OWN_LDR) begin
                r_ldr_busy <= 1'b1;
            end else if (ldr_ack) begin
                r_ldr_busy <= 1'b0;
            end
        end
    end

    // Counts denied cycles (video wins included); holds while the loader is busy.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ldr_wait <= '0;
        end else if (!ldr_req || (w_grant == OWN_LDR)) begin
            r_ldr_wait <= '0;
        end else if (w_ldr_elig && !w_ldr_starved) begin
            r_ldr_wait <= r_ldr_wait + CW'(1);
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_we   = r_mem_we;
    assign mem_din  = r_mem_din;

    vram_arb_retpipe #(
        .DW(DW)
    ) u_retpipe (
        .i_clk       (clk_sys),
        .i_rst       (reset),
        .i_tag       (w_tag),
        .i_mem_dout  (mem_dout),
        .o_vid_dout  (vid_dout),
        .o_vid_valid (vid_valid),
        .o_cpu_dout  (cpu_dout),
        .o_cpu_ack   (cpu_ack),
        .o_ldr_dout  (ldr_dout),
        .o_ldr_ack   (ldr_ack)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter with a read-first, 1-cycle-latency BRAM model
// whose initial content is addr[7:0] ^ addr[14:8].
module tb_vram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [7:0]  vid_dout;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ldr_req;
    logic        ldr_we;
    logic [14:0] ldr_addr;
    logic [7:0]  ldr_din;
    logic [7:0]  ldr_dout;
    logic        ldr_ack;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter #(
        .AW(15),
        .DW(8),
        .LDR_MAX_WAIT(16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_dout  (vid_dout),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_din   (ldr_din),
        .ldr_dout  (ldr_dout),
        .ldr_ack   (ldr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] init_val(input int unsigned a);
        logic [14:0] x;
        x = a[14:0];
        return x[7:0] ^ {1'b0, x[14:8]};
    endfunction

    logic [7:0] ram [0:32767];
    bit         ram_ready = 1'b0;

    always @(posedge clk_sys) begin
        if (!ram_ready) begin
            for (int unsigned i = 0; i < 32768; i++) begin
                ram[i] <= init_val(i);
            end
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
            end
            mem_dout <= ram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned who;   // 0 video, 1 cpu, 2 loader
        logic        we;
        logic [14:0] addr;
        logic [7:0]  din;
        int unsigned lat;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        vid_req = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [2:0] acks;
        logic [7:0] dout;
        case (v.who)
            0: begin vid_req = 1'b1; vid_addr = v.addr; end
            1: begin cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din; end
            default: begin ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_din = v.din; end
        endcase
        tick();
        chk($sformatf("vec%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
        chk($sformatf("vec%0d_mem_we", idx), 32'(mem_we), 32'(v.we));
        if (v.we) begin
            chk($sformatf("vec%0d_mem_din", idx), 32'(mem_din), 32'(v.din));
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            tick();
            acks = {vid_valid, cpu_ack, ldr_ack};
            dout = (v.who == 0) ? vid_dout : (v.who == 1) ? cpu_dout : ldr_dout;
            if (k == v.lat) begin
                chk($sformatf("vec%0d_acks_c%0d", idx, k), 32'(acks), 32'(3'b100 >> v.who));
                if (!v.we) begin
                    chk($sformatf("vec%0d_dout", idx), 32'(dout), 32'(v.exp));
                end
            end else begin
                chk($sformatf("vec%0d_acks_c%0d", idx, k), 32'(acks), 32'(0));
            end
        end
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{who: 1, we: 1'b0, addr: 15'h1800, din: 8'h00, lat: 2, exp: 8'h18};
        vecs[1]  = '{who: 1, we: 1'b1, addr: 15'h4000, din: 8'hA5, lat: 1, exp: 8'h00};
        vecs[2]  = '{who: 1, we: 1'b0, addr: 15'h4000, din: 8'h00, lat: 2, exp: 8'hA5};
        vecs[3]  = '{who: 2, we: 1'b0, addr: 15'h0123, din: 8'h00, lat: 2, exp: 8'h22};
        vecs[4]  = '{who: 2, we: 1'b1, addr: 15'h7FFF, din: 8'h3C, lat: 1, exp: 8'h00};
        vecs[5]  = '{who: 2, we: 1'b0, addr: 15'h7FFF, din: 8'h00, lat: 2, exp: 8'h3C};
        vecs[6]  = '{who: 0, we: 1'b0, addr: 15'h7FFF, din: 8'h00, lat: 2, exp: 8'h3C};
        vecs[7]  = '{who: 0, we: 1'b0, addr: 15'h0000, din: 8'h00, lat: 2, exp: 8'h00};
        vecs[8]  = '{who: 1, we: 1'b0, addr: 15'h5AA5, din: 8'h00, lat: 2, exp: 8'hFF};
        vecs[9]  = '{who: 0, we: 1'b0, addr: 15'h2C10, din: 8'h00, lat: 2, exp: 8'h3C};
        vecs[10] = '{who: 2, we: 1'b0, addr: 15'h4000, din: 8'h00, lat: 2, exp: 8'hA5};
        vecs[11] = '{who: 1, we: 1'b1, addr: 15'h0000, din: 8'h5E, lat: 1, exp: 8'h00};
        vecs[12] = '{who: 0, we: 1'b0, addr: 15'h0000, din: 8'h00, lat: 2, exp: 8'h5E};

        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_din = '0;
        repeat (3) tick();
        chk("rst_acks", 32'({vid_valid, cpu_ack, ldr_ack}), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_we_din", 32'({mem_we, mem_din}), 32'(0));
        chk("rst_douts", 32'({vid_dout, cpu_dout, ldr_dout}), 32'(0));
        reset = 1'b0;
        idle(2);
        chk("idle_no_we", 32'(mem_we), 32'(0));

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end
        idle(2);

        // Continuous video starves the CPU until a single-cycle gap.
        vid_req = 1'b1; vid_addr = 15'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1800;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("vidrun_mem_addr_%0d", j), 32'(mem_addr), 32'h0100);
            chk($sformatf("vidrun_cpu_ack_%0d", j), 32'(cpu_ack), 32'(0));
            if (j >= 3) begin
                chk($sformatf("vidrun_valid_%0d", j), 32'({vid_valid, vid_dout}), 32'h101);
            end
        end
        vid_req = 1'b0;
        tick();
        chk("gap_cpu_issue_addr", 32'(mem_addr), 32'h1800);
        chk("gap_cpu_issue_we", 32'(mem_we), 32'(0));
        vid_req = 1'b1;
        tick();
        chk("gap_cpu_ack_early", 32'(cpu_ack), 32'(0));
        tick();
        chk("gap_cpu_ack", 32'(cpu_ack), 32'(1));
        chk("gap_cpu_dout", 32'(cpu_dout), 32'h18);
        chk("gap_vid_valid_hole", 32'(vid_valid), 32'(0));
        idle(4);

        // Loader starvation: video gaps every 4 cycles, CPU always ready in the gap.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1800;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h0123;
        vid_addr = 15'h0200;
        for (int i = 0; i <= 20; i++) begin
            logic        gap;
            logic [14:0] exp_addr;
            gap = (i % 4 == 0) && (i > 0);
            vid_req = !gap;
            exp_addr = !gap ? 15'h0200 : (i == 16) ? 15'h0123 : 15'h1800;
            tick();
            chk($sformatf("starve_mem_addr_c%0d", i + 1), 32'(mem_addr), 32'(exp_addr));
            if (i + 1 == 19) begin
                chk("starve_ldr_ack", 32'(ldr_ack), 32'(1));
                chk("starve_ldr_dout", 32'(ldr_dout), 32'h22);
            end
        end
        idle(6);

        // All three in one cycle: VID, CPU, LDR issued back to back.
        vid_req = 1'b1; vid_addr = 15'h0300;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_din = 8'h11;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 15'h0020; ldr_din = 8'h22;
        tick();
        chk("simul_vid_addr", 32'({mem_we, mem_addr}), 32'h0300);
        vid_req = 1'b0;
        tick();
        chk("simul_cpu_issue", 32'({mem_we, mem_addr, mem_din}), 32'({1'b1, 15'h0010, 8'h11}));
        cpu_req = 1'b0;
        tick();
        chk("simul_ldr_issue", 32'({mem_we, mem_addr, mem_din}), 32'({1'b1, 15'h0020, 8'h22}));
        chk("simul_cpu_ack", 32'(cpu_ack), 32'(1));
        ldr_req = 1'b0;
        tick();
        chk("simul_ldr_ack", 32'({ldr_ack, mem_we}), 32'b10);
        idle(3);

        // CPU write with req dropped one cycle after issue.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0555; cpu_din = 8'h77;
        tick();
        chk("drop_issue", 32'({mem_we, mem_addr, mem_din}), 32'({1'b1, 15'h0555, 8'h77}));
        tick();
        chk("drop_ack", 32'(cpu_ack), 32'(1));
        chk("drop_no_reissue_a", 32'(mem_we), 32'(0));
        cpu_req = 1'b0;
        tick();
        chk("drop_no_reissue_b", 32'({mem_we, cpu_ack}), 32'(0));
        tick();
        chk("drop_no_second_ack", 32'(cpu_ack), 32'(0));
        v = '{who: 2, we: 1'b0, addr: 15'h0555, din: 8'h00, lat: 2, exp: 8'h77};
        run_vec(v, 13);
        idle(2);

        // Async reset in the middle of a CPU read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1800;
        tick();
        cpu_req = 1'b0;
        tick();
        #1 reset = 1'b1;
        #1;
        chk("midrst_acks", 32'({vid_valid, cpu_ack, ldr_ack}), 32'(0));
        chk("midrst_mem", 32'({mem_we, mem_addr, mem_din}), 32'(0));
        chk("midrst_douts", 32'({vid_dout, cpu_dout, ldr_dout}), 32'(0));
        #2 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("midrst_no_ack_%0d", k), 32'({vid_valid, cpu_ack, ldr_ack}), 32'(0));
        end
        run_vec(vecs[0], 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
